// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_IFU,
    ARB_BUSY_LSU
  } arb_state_t;

  // Counter width able to hold the values 0..max_streak inclusive.
  function automatic int unsigned streak_w(input int unsigned max_streak);
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core (IFU/LSU), the arbiter and the single-port memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import unified_mem_arbiter_pkg::*;

  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_gnt;
  logic              ifu_rvalid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req;
  logic              lsu_we;
  mem_size_t         lsu_size;
  logic              lsu_zero_extend;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req;
  logic              mem_we;
  mem_size_t         mem_size;
  logic              mem_zero_extend;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // The arbiter's view: requests and memory responses in, grants and memory requests out.
  modport slave (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_size, lsu_zero_extend, lsu_addr, lsu_wdata,
    input  mem_rvalid, mem_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output mem_req, mem_we, mem_size, mem_zero_extend, mem_addr, mem_wdata
  );

  // The environment's view: the core requesters plus the memory responder.
  modport master (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_size, lsu_zero_extend, lsu_addr, lsu_wdata,
    output mem_rvalid, mem_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  mem_req, mem_we, mem_size, mem_zero_extend, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_streak_counter.sv
// Counts consecutive LSU grants taken while the IFU waits; saturates at MAX_STREAK.
module arb_streak_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic streak_max
);

  localparam int unsigned CNT_W = streak_w(MAX_STREAK);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_STREAK);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign streak_max = (cnt_q == MAX_VAL);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one
// transaction outstanding, data priority with a bounded streak to keep fetch alive.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       streak_max;
  logic       cpl, issue_slot, lsu_win, ifu_win, grant_ifu, grant_lsu;

  always_comb begin
    // A completion frees the memory in the same cycle, so a new request can issue alongside it.
    cpl        = !reset && (state_q != ARB_IDLE) && bus.mem_rvalid;
    issue_slot = !reset && ((state_q == ARB_IDLE) || cpl);
    lsu_win    = bus.lsu_req && !(bus.ifu_req && streak_max);
    ifu_win    = bus.ifu_req && !lsu_win;
    grant_lsu  = issue_slot && lsu_win;
    grant_ifu  = issue_slot && ifu_win;

    state_d = state_q;
    if (issue_slot) begin
      if (grant_lsu) begin
        state_d = ARB_BUSY_LSU;
      end else if (grant_ifu) begin
        state_d = ARB_BUSY_IFU;
      end else begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_comb begin
    bus.mem_req         = grant_lsu || grant_ifu;
    bus.mem_we          = 1'b0;
    bus.mem_size        = MEM_BYTE;
    bus.mem_zero_extend = 1'b0;
    bus.mem_addr        = {ADDR_W{1'b0}};
    bus.mem_wdata       = {DATA_W{1'b0}};
    if (grant_lsu) begin
      bus.mem_we          = bus.lsu_we;
      bus.mem_size        = bus.lsu_size;
      bus.mem_zero_extend = bus.lsu_zero_extend;
      bus.mem_addr        = bus.lsu_addr;
      bus.mem_wdata       = bus.lsu_wdata;
    end else if (grant_ifu) begin
      bus.mem_size = MEM_WORD;
      bus.mem_addr = bus.ifu_addr;
    end

    bus.ifu_gnt    = grant_ifu;
    bus.lsu_gnt    = grant_lsu;
    bus.ifu_rvalid = cpl && (state_q == ARB_BUSY_IFU);
    bus.lsu_rvalid = cpl && (state_q == ARB_BUSY_LSU);
    bus.ifu_rdata  = bus.ifu_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.lsu_rdata  = bus.lsu_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  arb_streak_counter #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak (
    .clk        (clk),
    .reset      (reset),
    .inc        (grant_lsu && bus.ifu_req),
    .clr        (grant_ifu),
    .streak_max (streak_max)
  );

  // A response with no owner (e.g. after reset dropped a transaction) is discarded.
  a_stray_rvalid: assert property (@(posedge clk) disable iff (reset)
    !((state_q == ARB_IDLE) && bus.mem_rvalid))
    else $warning("stray mem_rvalid ignored while idle");

  a_ifu_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.ifu_req && !bus.ifu_gnt) |=> (bus.ifu_req && $stable(bus.ifu_addr)))
    else $error("ifu request changed before grant");

  a_lsu_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.lsu_req && !bus.lsu_gnt) |=> (bus.lsu_req && $stable(bus.lsu_addr) &&
      $stable(bus.lsu_we) && $stable(bus.lsu_size) && $stable(bus.lsu_zero_extend) &&
      $stable(bus.lsu_wdata)))
    else $error("lsu request changed before grant");

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: drivers issue queued requests, a monitor checks grants/responses.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr; logic we; mem_size_t size; logic zx; logic [31:0] wdata; int dly;
  } txn_t;
  typedef struct {
    logic [1:0] who; logic [31:0] addr; logic we; mem_size_t size; logic zx;
    logic [31:0] wdata; logic b2b;
  } exp_gnt_t;
  typedef struct {
    logic [1:0] who; logic [31:0] data; logic chk_data;
  } exp_rsp_t;

  localparam logic [1:0] WHO_I = 2'b10;
  localparam logic [1:0] WHO_L = 2'b01;

  txn_t     ifu_q[$];
  txn_t     lsu_q[$];
  exp_gnt_t eg_q[$];
  exp_rsp_t er_q[$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_gnt_cyc = 0;
  logic mem_auto = 1'b1;
  logic inject_stray = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_txn(input logic is_ifu, input logic [31:0] addr, input logic we,
                         input mem_size_t size, input logic zx, input logic [31:0] wdata,
                         input int dly);
    txn_t t;
    t.addr = addr; t.we = we; t.size = size; t.zx = zx; t.wdata = wdata; t.dly = dly;
    if (is_ifu) ifu_q.push_back(t);
    else        lsu_q.push_back(t);
  endtask

  task automatic exp_gnt(input logic [1:0] who, input logic [31:0] addr, input logic we,
                         input mem_size_t size, input logic zx, input logic [31:0] wdata,
                         input logic b2b);
    exp_gnt_t e;
    e.who = who; e.addr = addr; e.we = we; e.size = size; e.zx = zx; e.wdata = wdata; e.b2b = b2b;
    eg_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [1:0] who, input logic [31:0] data, input logic chk_data);
    exp_rsp_t r;
    r.who = who; r.data = data; r.chk_data = chk_data;
    er_q.push_back(r);
  endtask

  // Memory contents: 0x100 holds an addi; every other word echoes its address in the top half.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : {a[15:0], 16'hC0DE};
  endfunction

  // One-cycle memory responder
  initial begin
    logic        nxt;
    logic [31:0] d;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      nxt = (bus.mem_req && mem_auto) || inject_stray;
      d   = mem_model(bus.mem_addr);
      @(posedge clk); #1;
      bus.mem_rvalid = nxt;
      bus.mem_rdata  = nxt ? d : 32'h0;
    end
  end

  // IFU requester
  initial begin
    txn_t t;
    int   n;
    bus.ifu_req  = 1'b0;
    bus.ifu_addr = 32'h0;
    @(posedge clk); #1;
    forever begin
      if (ifu_q.size() > 0) begin
        t = ifu_q.pop_front();
        if (t.dly > 0) begin
          bus.ifu_req = 1'b0;
          repeat (t.dly) begin @(posedge clk); #1; end
        end
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = t.addr;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ifu_gnt && n < 60);
        chk("ifu_gnt_seen", bus.ifu_gnt, 1);
        @(posedge clk); #1;
      end else begin
        bus.ifu_req = 1'b0;
        @(posedge clk); #1;
      end
    end
  end

  // LSU requester
  initial begin
    txn_t t;
    int   n;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_size = MEM_BYTE;
    bus.lsu_zero_extend = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_wdata = 32'h0;
    @(posedge clk); #1;
    forever begin
      if (lsu_q.size() > 0) begin
        t = lsu_q.pop_front();
        if (t.dly > 0) begin
          bus.lsu_req = 1'b0;
          repeat (t.dly) begin @(posedge clk); #1; end
        end
        bus.lsu_req = 1'b1; bus.lsu_we = t.we; bus.lsu_size = t.size;
        bus.lsu_zero_extend = t.zx; bus.lsu_addr = t.addr; bus.lsu_wdata = t.wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.lsu_gnt && n < 60);
        chk("lsu_gnt_seen", bus.lsu_gnt, 1);
        @(posedge clk); #1;
      end else begin
        bus.lsu_req = 1'b0;
        @(posedge clk); #1;
      end
    end
  end

  // Monitor: responses first so a same-cycle grant does not disturb the latency reference
  initial begin
    exp_gnt_t e;
    exp_rsp_t r;
    forever begin
      @(negedge clk);
      if (bus.ifu_rvalid || bus.lsu_rvalid) begin
        if (er_q.size() == 0) begin
          chk("unexpected_rvalid", {bus.ifu_rvalid, bus.lsu_rvalid}, 0);
        end else begin
          r = er_q.pop_front();
          chk("rsp_who", {bus.ifu_rvalid, bus.lsu_rvalid}, r.who);
          if (r.chk_data)
            chk("rsp_data", (r.who == WHO_I) ? bus.ifu_rdata : bus.lsu_rdata, r.data);
          chk("rsp_latency", cyc - last_gnt_cyc, 1);
        end
      end
      if (bus.mem_req) begin
        if (eg_q.size() == 0) begin
          chk("unexpected_mem_req", bus.mem_req, 0);
        end else begin
          e = eg_q.pop_front();
          chk("gnt_who", {bus.ifu_gnt, bus.lsu_gnt}, e.who);
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_we", bus.mem_we, e.we);
          chk("mem_size", bus.mem_size, e.size);
          chk("mem_zero_extend", bus.mem_zero_extend, e.zx);
          chk("mem_wdata", bus.mem_wdata, e.wdata);
          if (e.b2b) chk("b2b_same_cycle_as_rvalid", bus.mem_rvalid, 1);
        end
        last_gnt_cyc = cyc;
      end else if (bus.ifu_gnt || bus.lsu_gnt) begin
        chk("gnt_without_mem_req", {bus.ifu_gnt, bus.lsu_gnt}, 0);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((eg_q.size() + er_q.size() + ifu_q.size() + lsu_q.size()) > 0 && n < 200) begin
      @(posedge clk); n++;
    end
    chk("drain_pending", eg_q.size() + er_q.size() + ifu_q.size() + lsu_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both requesting; LSU wins the first free cycle
    add_txn(1'b0, 32'h3000, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    add_txn(1'b1, 32'h0000, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    exp_gnt(WHO_L, 32'h3000, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
    exp_gnt(WHO_I, 32'h0000, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
    exp_rsp(WHO_L, 32'h3000C0DE, 1'b1);
    exp_rsp(WHO_I, 32'h0000C0DE, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs_quiet", {bus.ifu_gnt, bus.lsu_gnt, bus.ifu_rvalid, bus.lsu_rvalid,
                                  bus.mem_req}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_after_reset_lsu_gnt", {bus.ifu_gnt, bus.lsu_gnt}, WHO_L);
    drain();

    // IFU fetch alone
    @(negedge clk);
    add_txn(1'b1, 32'h100, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    exp_gnt(WHO_I, 32'h100, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
    exp_rsp(WHO_I, 32'h00500093, 1'b1);
    drain();

    // Both requesting: L,L,L,L,I,L,L,L,L,I
    @(negedge clk);
    add_txn(1'b1, 32'h200, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    add_txn(1'b1, 32'h204, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    for (int i = 0; i < 8; i++)
      add_txn(1'b0, 32'h1000 + 32'(4 * i), 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        exp_gnt(WHO_I, (i == 4) ? 32'h200 : 32'h204, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
        exp_rsp(WHO_I, (i == 4) ? 32'h0200C0DE : 32'h0204C0DE, 1'b1);
      end else begin
        int k;
        k = (i < 4) ? i : i - 1;
        exp_gnt(WHO_L, 32'h1000 + 32'(4 * k), 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
        exp_rsp(WHO_L, ((32'h1000 + 32'(4 * k)) << 16) | 32'hC0DE, 1'b1);
      end
    end
    drain();

    // Word store, then a zero-extended byte load
    @(negedge clk);
    add_txn(1'b0, 32'h2000, 1'b1, MEM_WORD, 1'b0, 32'hDEADBEEF, 0);
    add_txn(1'b0, 32'h2001, 1'b0, MEM_BYTE, 1'b1, 32'h0, 0);
    exp_gnt(WHO_L, 32'h2000, 1'b1, MEM_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
    exp_rsp(WHO_L, 32'h0, 1'b0);
    exp_gnt(WHO_L, 32'h2001, 1'b0, MEM_BYTE, 1'b1, 32'h0, 1'b0);
    exp_rsp(WHO_L, 32'h2001C0DE, 1'b1);
    drain();

    // LSU request arrives in the cycle the IFU completes: issued in that same cycle
    @(negedge clk);
    add_txn(1'b1, 32'h300, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    add_txn(1'b0, 32'h2004, 1'b0, MEM_WORD, 1'b0, 32'h0, 1);
    exp_gnt(WHO_I, 32'h300, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
    exp_gnt(WHO_L, 32'h2004, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b1);
    exp_rsp(WHO_I, 32'h0300C0DE, 1'b1);
    exp_rsp(WHO_L, 32'h2004C0DE, 1'b1);
    drain();

    // Reset while BUSY_LSU, then a stray completion
    mem_auto = 1'b0;
    @(negedge clk);
    add_txn(1'b0, 32'h4000, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    exp_gnt(WHO_L, 32'h4000, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
    begin
      int n = 0;
      while (eg_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_quiet", {bus.ifu_gnt, bus.lsu_gnt, bus.ifu_rvalid, bus.lsu_rvalid,
                            bus.mem_req}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    inject_stray = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    inject_stray = 1'b0;
    @(negedge clk);
    chk("stray_mem_rvalid_present", bus.mem_rvalid, 1);
    chk("stray_no_rvalid_out", {bus.ifu_rvalid, bus.lsu_rvalid, bus.mem_req}, 0);
    chk("state_idle_after_stray", dut.state_q, ARB_IDLE);
    @(posedge clk); #1;
    mem_auto = 1'b1;
    @(negedge clk);
    add_txn(1'b0, 32'h4004, 1'b0, MEM_WORD, 1'b0, 32'h0, 0);
    exp_gnt(WHO_L, 32'h4004, 1'b0, MEM_WORD, 1'b0, 32'h0, 1'b0);
    exp_rsp(WHO_L, 32'h4004C0DE, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
